// File: rtl/onchip_mem_stream_reader.sv
// Streams LENGTH consecutive words out of a 1-cycle-latency on-chip RAM as one
// SOP/EOP-framed packet, throttled by a 2-entry skid buffer and read credits.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for start; base/length sampled here
//  S_RUN   | issuing reads whenever the buffer has room for the word
//  S_DRAIN | all reads issued; waiting for the eop beat to be accepted
//  S_DONE  | one-cycle done pulse, then back to idle
module onchip_mem_stream_reader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              first_q, first_d;
  logic              infl_q, infl_sop_q, infl_eop_q;
  logic [1:0]        cnt_q;
  logic [DATA_W-1:0] d0_q, d1_q;
  logic              s0_q, e0_q, s1_q, e1_q;
  logic [2:0]        pend;
  logic              pop, push, issue, last_issue;

  assign pop        = (cnt_q != 2'd0) & out_ready;
  assign push       = infl_q;
  // Words already owed to the buffer (stored + in flight), net of this cycle's pop.
  assign pend       = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign issue      = (state_q == S_RUN) && (pend < 3'd2);
  assign last_issue = (rem_q == LEN_W'(1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    first_d = first_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = length;
          first_d = 1'b1;
          state_d = (length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          first_d = 1'b0;
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && e0_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      first_q    <= 1'b0;
      infl_q     <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      first_q    <= first_d;
      infl_q     <= issue;
      infl_sop_q <= issue & first_q;
      infl_eop_q <= issue & last_issue;
    end
  end

  // Entry 0 is the head and drives the stream outputs directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 2'd0;
      d0_q  <= '0;
      d1_q  <= '0;
      s0_q  <= 1'b0;
      e0_q  <= 1'b0;
      s1_q  <= 1'b0;
      e1_q  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            d0_q <= mem_readdata;
            s0_q <= infl_sop_q;
            e0_q <= infl_eop_q;
          end else begin
            d1_q <= mem_readdata;
            s1_q <= infl_sop_q;
            e1_q <= infl_eop_q;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          d0_q  <= d1_q;
          s0_q  <= s1_q;
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            d0_q <= mem_readdata;
            s0_q <= infl_sop_q;
            e0_q <= infl_eop_q;
          end else begin
            d0_q <= d1_q;
            s0_q <= s1_q;
            e0_q <= e1_q;
            d1_q <= mem_readdata;
            s1_q <= infl_sop_q;
            e1_q <= infl_eop_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign mem_address    = addr_q;
  assign mem_chipselect = issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign out_data       = d0_q;
  assign out_valid      = (cnt_q != 2'd0);
  assign out_sop        = s0_q;
  assign out_eop        = e0_q;

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Bench for onchip_mem_stream_reader: RAM model plus a packet-level scoreboard
// that predicts every beat from base/length and the memory contents.
module tb_onchip_mem_stream_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] length;
  logic        busy, done;
  logic [13:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic [31:0] out_data;
  logic        out_valid, out_ready, out_sop, out_eop;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:16383];
  logic [13:0] ram_a = 14'd0;

  always #5 clk = ~clk;

  // RAM: address registered on an issued read, q read combinationally from it.
  always @(posedge clk) if (mem_chipselect) ram_a <= mem_address;
  assign mem_readdata = mem[ram_a];

  onchip_mem_stream_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_cs"}, 64'(mem_chipselect), 64'(0));
    check({tag, "_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_sop"}, 64'(out_sop), 64'(0));
    check({tag, "_eop"}, 64'(out_eop), 64'(0));
    check({tag, "_addr"}, 64'(mem_address), 64'(0));
  endtask

  // One packet from start pulse to idle. pct = out_ready probability (%);
  // exact = ready held high and the cycle-by-cycle schedule is checked.
  task automatic xfer(input int base, input int len, input int pct, input bit exact,
                      input bit repulse);
    int issued, acc, fin, done_cyc, ndone, nsop, neop, lim;
    logic pv, pr, ps, pe, rdy, popc;
    logic [31:0] pd;
    issued = 0; acc = 0; done_cyc = -1; ndone = 0; nsop = 0; neop = 0;
    fin = (len == 0) ? 1 : 1000000;
    lim = len * 20 + 40;
    pv = 1'b0; pr = 1'b0; ps = 1'b0; pe = 1'b0; pd = '0;
    @(negedge clk);
    start = 1'b1; base_addr = 14'(base); length = 15'(len);
    out_ready = exact ? 1'b1 : 1'($urandom_range(0, 1));
    #4;
    check("c0_busy", 64'(busy), 64'(0));
    check("c0_cs", 64'(mem_chipselect), 64'(0));
    for (int cyc = 1; cyc <= lim; cyc++) begin
      @(negedge clk);
      start     = repulse && (cyc == 2 || cyc == 4);
      base_addr = 14'($urandom);
      length    = 15'($urandom_range(0, 9));
      rdy       = exact ? 1'b1 : ($urandom_range(0, 99) < pct);
      out_ready = rdy;
      #4;
      popc = out_valid & out_ready;
      if (exact) begin
        check("cs_sched", 64'(mem_chipselect), 64'(cyc >= 1 && cyc <= len));
        check("valid_sched", 64'(out_valid), 64'(cyc >= 3 && cyc <= len + 2));
      end
      if (mem_chipselect) begin
        check("cs_addr", 64'(mem_address), 64'((base + issued) & 'h3FFF));
        check("cs_room", 64'(((issued - acc) - int'(popc)) < 2), 64'(1));
        check("cs_extra_read", 64'(issued < len), 64'(1));
        issued++;
      end
      if (pv && !pr) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data", 64'(out_data), 64'(pd));
        check("hold_sop", 64'(out_sop), 64'(ps));
        check("hold_eop", 64'(out_eop), 64'(pe));
      end
      if (popc) begin
        check("extra_word", 64'(acc < len), 64'(1));
        check("beat_data", 64'(out_data), 64'(mem[(base + acc) & 'h3FFF]));
        check("beat_sop", 64'(out_sop), 64'(acc == 0));
        check("beat_eop", 64'(out_eop), 64'(acc == len - 1));
        nsop += int'(out_sop);
        neop += int'(out_eop);
        acc++;
        if (acc == len) fin = cyc + 1;
      end
      if (len != 0) begin
        check("busy", 64'(busy), 64'(cyc < fin));
        check("done", 64'(done), 64'(cyc == fin));
      end
      if (done) begin
        if (done_cyc < 0) done_cyc = cyc;
        ndone++;
      end
      pv = out_valid; pr = rdy; pd = out_data; ps = out_sop; pe = out_eop;
      if (cyc >= fin + 2) break;
    end
    check("reads_issued", 64'(issued), 64'(len));
    check("words_accepted", 64'(acc), 64'(len));
    check("done_pulses", 64'(ndone), 64'(1));
    if (len != 0) begin
      check("sop_count", 64'(nsop), 64'(1));
      check("eop_count", 64'(neop), 64'(1));
    end else begin
      check("len0_done_window", 64'(done_cyc >= 1 && done_cyc <= 2), 64'(1));
    end
    check("end_idle_busy", 64'(busy), 64'(0));
    check("end_idle_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;

    // T1: reset values and quiet idle after release
    #1;
    check_reset_values("t1_rst");
    check("t1_mem_write", 64'(mem_write), 64'(0));
    check("t1_byteen", 64'(mem_byteenable), 64'(4'hF));
    check("t1_clken", 64'(mem_clken), 64'(1));
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      #4;
      check("t1_idle_valid", 64'(out_valid), 64'(0));
      check("t1_idle_cs", 64'(mem_chipselect), 64'(0));
    end

    // T2: exact schedule, ready always high
    xfer('h010, 4, 100, 1'b1, 1'b0);
    // T3: long packet under random backpressure
    xfer(0, 64, 50, 1'b0, 1'b0);
    xfer(int'($urandom_range(0, 16383)), 17, 30, 1'b0, 1'b0);
    // T4: empty and single-beat packets
    xfer('h100, 0, 100, 1'b1, 1'b0);
    xfer('h123, 1, 100, 1'b1, 1'b0);
    xfer('h124, 1, 40, 1'b0, 1'b0);
    // T5: address wrap
    xfer('h3FFE, 4, 100, 1'b1, 1'b0);
    xfer('h3FFD, 6, 60, 1'b0, 1'b0);
    // T6: start re-pulsed while busy is ignored
    xfer('h0A0, 8, 100, 1'b1, 1'b1);
    xfer('h0B0, 8, 50, 1'b0, 1'b1);

    // T6: reset mid-packet under backpressure
    @(negedge clk);
    start = 1'b1; base_addr = 14'h200; length = 15'd8; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #2;
    check("t6_pre_busy", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    check_reset_values("t6_rst");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      #4;
      check("t6_post_valid", 64'(out_valid), 64'(0));
      check("t6_post_cs", 64'(mem_chipselect), 64'(0));
      check("t6_post_done", 64'(done), 64'(0));
    end
    xfer('h300, 5, 100, 1'b1, 1'b0);
    xfer('h310, 9, 50, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
